axis_byte_window: RTL and testbench
===================================

Name: axis_byte_window

Overview:
- Upstream feeder for the byte realigner. Cuts a byte-granular window out of a word-aligned 32-bit AXI-Stream, such as a memory read stream.
- Each command gives a start byte offset within the first word and a byte length. The block emits the covering words with tkeep marking only the window bytes, tlast on the final word, and tuser carrying the destination offset the realigner consumes.
- Single clock domain. One registered output stage.

Parameters:
- LEN_W, 16, width of cmd_len; maximum window is 2^LEN_W-1 bytes.
- BIG_ENDIAN, "TRUE", byte-lane mapping:
  - "TRUE": byte 0 is tdata[31:24] and its keep bit is tkeep[3].
  - otherwise: byte 0 is tdata[7:0] and its keep bit is tkeep[0].

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_offset  in  2  index of the first window byte within the first input word.
- cmd_len  in  LEN_W  window length in bytes.
- cmd_dst  in  2  destination offset, driven on m_tuser.
- s_tdata  in  32  input word.
- s_tlast  in  1  input packet end; used only with the optional feature.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  32  output word.
- m_tkeep  out  4  output byte enables.
- m_tlast  out  1  last word of the window.
- m_tuser  out  2  cmd_dst of the current window.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- err_tlast  out  1  sticky tlast-mismatch flag; tied 0 without the optional feature.

Behaviour:
- States: IDLE, ACTIVE, DRAIN (DRAIN exists only with the optional feature).
- cmd_ready = (state==IDLE).
  - On cmd accept, latch off=cmd_offset, rem=cmd_len, dst=cmd_dst.
  - Go to ACTIVE if cmd_len!=0.
  - If cmd_len==0, stay IDLE: no input consumed, no output produced.
- s_tready = (state==ACTIVE || state==DRAIN) && (!m_tvalid || m_tready).
  - Input is never consumed in IDLE.
- ACTIVE beat (s_tvalid && s_tready):
  - avail = 4-off; cnt = min(rem, avail).
  - Keep covers bytes off .. off+cnt-1, contiguous, in lane order per BIG_ENDIAN.
  - rem -= cnt; off <= 0 after the first beat.
  - Output register loads s_tdata unmodified, the keep mask, tlast=(rem-cnt==0), tuser=dst.
  - When the final beat is consumed, go to IDLE.
- Word count per window: ceil((cmd_offset+cmd_len)/4).
  - Bytes outside the window keep their data but have keep=0.
- Timing:
  - Earliest first input accept is the cycle after cmd accept.
  - Latency: input beat accepted in cycle N gives m_tvalid in cycle N+1.
  - Throughput: 1 word/cycle while m_tready=1.
- Output register:
  - Holds stable while m_tvalid && !m_tready.
  - Clears m_tvalid on m_tready when no new beat loads.
  - Load and drain may occur in the same cycle.
- A new command may be accepted while the previous window's last word still waits on m_tready.
- Reset (async, any state, mid-window included):
  - state=IDLE, so cmd_ready=1.
  - m_tvalid=0, m_tlast=0, m_tkeep=0, m_tuser=0, m_tdata=0, err_tlast=0.
  - The in-flight window is discarded.
- Arithmetic:
  - rem is LEN_W bits.
  - off+cnt never exceeds 4; the min() is computed at 3 bits.

Optional Feature:
- Macro: AXIS_BYTE_WINDOW_TLAST_CHECK_EN.
- Enabled, early tlast: s_tlast=1 on a non-final window beat.
  - That beat is emitted with m_tlast=1.
  - The rest of the window is abandoned; state goes to IDLE.
  - err_tlast sets.
- Enabled, missing tlast: final window beat with s_tlast=0.
  - The beat is emitted normally with m_tlast=1.
  - State goes to DRAIN.
  - err_tlast sets.
- DRAIN:
  - Accepts and discards input; produces no output; cmd_ready=0.
  - Leaves to IDLE on the beat with s_tlast=1.
  - s_tready in DRAIN ignores output backpressure, i.e. it is 1.
- err_tlast clears on the next cmd accept.
- Disabled: s_tlast ignored, no DRAIN state, err_tlast=0.

Test Plan:
- cmd off=1 len=6 dst=2, input 0x00112233, 0x44556677, m_tready=1 (BIG_ENDIAN) -> two beats:
  - beat 1: keep 4'b0111, tlast 0, tuser 2.
  - beat 2: keep 4'b1110, tlast 1.
  - data passes through unchanged; cmd_ready back in the cycle after the second accept.
- cmd off=0 len=12, three words, continuous -> three beats, keep 4'b1111, tlast on the 3rd, one beat per cycle, 1-cycle latency.
- cmd off=3 len=1 with BIG_ENDIAN="FALSE" -> one beat, keep 4'b1000, tlast 1.
- cmd len=0 then cmd off=2 len=2 -> first consumes no input and emits nothing; second emits one beat with keep 4'b0011 (BIG_ENDIAN).
- off=0 len=16, m_tready toggling 1,0,0,1 -> output data/keep stable while stalled, no beat lost or duplicated; assert aresetn low mid-window -> m_tvalid=0 at once, cmd_ready=1 after release.
- With the macro, cmd len=8 off=0, s_tlast on word 1 -> beat 1 has m_tlast=1, err_tlast=1, state IDLE. Then cmd len=4 with input tlast on word 3 -> one beat out, words 2-3 discarded, err_tlast stays set after DRAIN exits to IDLE.

Source files
------------

// File: rtl/axis_byte_window_if.sv
// Bundle of the command, input-stream and output-stream signals of axis_byte_window.
// slave = the window block's view, master = the view of whatever drives and consumes it.
interface axis_byte_window_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_offset;
  logic [LEN_W-1:0] cmd_len;
  logic [1:0]       cmd_dst;

  logic [31:0]      s_tdata;
  logic             s_tlast;
  logic             s_tvalid;
  logic             s_tready;

  logic [31:0]      m_tdata;
  logic [3:0]       m_tkeep;
  logic             m_tlast;
  logic [1:0]       m_tuser;
  logic             m_tvalid;
  logic             m_tready;

  logic             err_tlast;

  modport slave (
    input  cmd_valid, cmd_offset, cmd_len, cmd_dst,
    output cmd_ready,
    input  s_tdata, s_tlast, s_tvalid,
    output s_tready,
    output m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid,
    input  m_tready,
    output err_tlast
  );

  modport master (
    output cmd_valid, cmd_offset, cmd_len, cmd_dst,
    input  cmd_ready,
    output s_tdata, s_tlast, s_tvalid,
    input  s_tready,
    input  m_tdata, m_tkeep, m_tlast, m_tuser, m_tvalid,
    output m_tready,
    input  err_tlast
  );
endinterface

// File: rtl/axis_byte_window.sv
// Cuts a byte window out of a word-aligned 32-bit stream: tkeep marks window bytes, tuser carries cmd_dst.
// Define AXIS_BYTE_WINDOW_TLAST_CHECK_EN to check s_tlast against the window end (DRAIN state, err_tlast).
module axis_byte_window #(
  parameter int    LEN_W      = 16,
  parameter string BIG_ENDIAN = "TRUE"
) (
  input  logic              aclk,
  input  logic              aresetn,
  axis_byte_window_if.slave bus
);

  localparam bit BE = (BIG_ENDIAN == "TRUE");

`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} state_t;
`endif

  state_t           state_reg;
  state_t           state_next;

  logic [1:0]       off_reg;
  logic [LEN_W-1:0] rem_reg;
  logic [1:0]       dst_reg;

  logic [31:0]      m_tdata_reg;
  logic [3:0]       m_tkeep_reg;
  logic             m_tlast_reg;
  logic [1:0]       m_tuser_reg;
  logic             m_tvalid_reg;
  logic             err_tlast_reg;

  logic             cmd_rdy;
  logic             s_rdy;
  logic             cmd_fire;
  logic             s_fire;
  logic             load;

  logic [2:0]       avail;
  logic [2:0]       rem_small;
  logic [2:0]       cnt;
  logic [2:0]       win_end;
  logic [LEN_W-1:0] rem_after;
  logic             final_beat;
  logic             beat_last;
  logic [3:0]       byte_en;
  logic [3:0]       lane_keep;

  assign cmd_fire = bus.cmd_valid && cmd_rdy;
  assign s_fire   = bus.s_tvalid && s_rdy;
  assign load     = s_fire && (state_reg == ACTIVE);

  // Bytes taken from the current word; rem is clamped to 4 first so the min() stays 3 bits wide.
  assign avail      = 3'd4 - {1'b0, off_reg};
  assign rem_small  = (rem_reg < LEN_W'(4)) ? rem_reg[2:0] : 3'd4;
  assign cnt        = (rem_small < avail) ? rem_small : avail;
  assign win_end    = {1'b0, off_reg} + cnt;
  assign rem_after  = rem_reg - LEN_W'(cnt);
  assign final_beat = (rem_after == '0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_en[gi] = ({1'b0, off_reg} <= 3'(gi)) && (3'(gi) < win_end);
      if (BE) begin : g_be
        assign lane_keep[3-gi] = byte_en[gi];
      end else begin : g_le
        assign lane_keep[gi] = byte_en[gi];
      end
    end
  endgenerate

`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
  logic tlast_mismatch;
  assign tlast_mismatch = bus.s_tlast != final_beat;
  // An early input tlast also terminates the window on the output side.
  assign beat_last      = final_beat || bus.s_tlast;
`else
  logic unused_s_tlast;
  assign unused_s_tlast = bus.s_tlast;
  assign beat_last      = final_beat;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_fire && (bus.cmd_len != '0)) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (s_fire) begin
`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
          if (final_beat) begin
            state_next = bus.s_tlast ? IDLE : DRAIN;
          end else if (bus.s_tlast) begin
            state_next = IDLE;
          end
`else
          if (final_beat) begin
            state_next = IDLE;
          end
`endif
        end
      end
`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
      DRAIN: begin
        if (bus.s_tvalid && bus.s_tlast) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_rdy = 1'b0;
    s_rdy   = 1'b0;
    case (state_reg)
      IDLE:   cmd_rdy = 1'b1;
      ACTIVE: s_rdy   = !m_tvalid_reg || bus.m_tready;
`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
      DRAIN:  s_rdy   = 1'b1;
`endif
      default: begin
        cmd_rdy = 1'b0;
        s_rdy   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      off_reg      <= '0;
      rem_reg      <= '0;
      dst_reg      <= '0;
      m_tdata_reg  <= '0;
      m_tkeep_reg  <= '0;
      m_tlast_reg  <= 1'b0;
      m_tuser_reg  <= '0;
      m_tvalid_reg <= 1'b0;
    end else begin
      if (cmd_fire) begin
        off_reg <= bus.cmd_offset;
        rem_reg <= bus.cmd_len;
        dst_reg <= bus.cmd_dst;
      end else if (load) begin
        off_reg <= '0;
        rem_reg <= rem_after;
      end

      if (load) begin
        m_tdata_reg  <= bus.s_tdata;
        m_tkeep_reg  <= lane_keep;
        m_tlast_reg  <= beat_last;
        m_tuser_reg  <= dst_reg;
        m_tvalid_reg <= 1'b1;
      end else if (bus.m_tready) begin
        m_tvalid_reg <= 1'b0;
      end
    end
  end

`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_tlast_reg <= 1'b0;
    end else if (cmd_fire) begin
      err_tlast_reg <= 1'b0;
    end else if (load && tlast_mismatch) begin
      err_tlast_reg <= 1'b1;
    end
  end
`else
  assign err_tlast_reg = 1'b0;
`endif

  assign bus.cmd_ready = cmd_rdy;
  assign bus.s_tready  = s_rdy;
  assign bus.m_tdata   = m_tdata_reg;
  assign bus.m_tkeep   = m_tkeep_reg;
  assign bus.m_tlast   = m_tlast_reg;
  assign bus.m_tuser   = m_tuser_reg;
  assign bus.m_tvalid  = m_tvalid_reg;
  assign bus.err_tlast = err_tlast_reg;

endmodule

// File: tb/tb_axis_byte_window.sv
// Randomized bench for axis_byte_window: big- and little-endian instances share stimulus and are
// checked against a byte-position model of the window.
module tb_axis_byte_window;

  localparam int LEN_W = 16;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [1:0]       cmd_offset = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [1:0]       cmd_dst = '0;
  logic [31:0]      s_tdata = '0;
  logic             s_tlast = 1'b0;
  logic             s_tvalid = 1'b0;
  logic             m_tready = 1'b0;

  always #5 aclk = ~aclk;

  axis_byte_window_if #(.LEN_W(LEN_W)) bus_be ();
  axis_byte_window_if #(.LEN_W(LEN_W)) bus_le ();

  assign bus_be.cmd_valid  = cmd_valid;
  assign bus_be.cmd_offset = cmd_offset;
  assign bus_be.cmd_len    = cmd_len;
  assign bus_be.cmd_dst    = cmd_dst;
  assign bus_be.s_tdata    = s_tdata;
  assign bus_be.s_tlast    = s_tlast;
  assign bus_be.s_tvalid   = s_tvalid;
  assign bus_be.m_tready   = m_tready;
  assign bus_le.cmd_valid  = cmd_valid;
  assign bus_le.cmd_offset = cmd_offset;
  assign bus_le.cmd_len    = cmd_len;
  assign bus_le.cmd_dst    = cmd_dst;
  assign bus_le.s_tdata    = s_tdata;
  assign bus_le.s_tlast    = s_tlast;
  assign bus_le.s_tvalid   = s_tvalid;
  assign bus_le.m_tready   = m_tready;

  axis_byte_window #(.LEN_W(LEN_W), .BIG_ENDIAN("TRUE")) dut_be (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_be)
  );
  axis_byte_window #(.LEN_W(LEN_W), .BIG_ENDIAN("FALSE")) dut_le (
    .aclk(aclk), .aresetn(aresetn), .bus(bus_le)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep_be;
    logic [3:0]  keep_le;
    logic        last;
    logic [1:0]  user;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] din_q[$];
  bit          tr_pat[$];
  int          tr_mode = 0;
  bit          gaps = 0;
  int          err_exp = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_value(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Keep bit of each lane: byte b of word k sits at stream position 4k+b.
  function automatic logic [3:0] lane_keep(int off, int len, int k, bit be);
    logic [3:0] kp;
    kp = '0;
    for (int b = 0; b < 4; b++) begin
      if ((4*k + b >= off) && (4*k + b < off + len)) kp[be ? 3-b : b] = 1'b1;
    end
    return kp;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
    case (tr_mode)
      0: m_tready = 1'b1;
      1: m_tready = ($urandom_range(0, 3) != 0);
      2: m_tready = (tr_pat.size() != 0) ? tr_pat.pop_front() : 1'b1;
      default: m_tready = 1'b0;
    endcase
  endtask

  // Issue one command and feed n_in input words, s_tlast on word tl_idx.
  task automatic run_cmd(int off, int len, int dst, int n_in, int tl_idx);
    int          nw;
    int          n_out;
    int          waits;
    bit          rdy;
    logic [31:0] w[];
    beat_t       b;
    nw    = (len == 0) ? 0 : (off + len + 3) / 4;
    n_out = nw;
`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
    if (tl_idx + 1 < n_out) n_out = tl_idx + 1;
`endif
    w = new[n_in];
    for (int k = 0; k < n_in; k++) w[k] = (din_q.size() != 0) ? din_q.pop_front() : $urandom();
    cmd_valid  = 1'b1;
    cmd_offset = off[1:0];
    cmd_len    = len[LEN_W-1:0];
    cmd_dst    = dst[1:0];
    waits      = 0;
    do begin
      @(negedge aclk);
      rdy = bus_be.cmd_ready;
      if (rdy) begin
        check_value("idle_s_tready", {bus_be.s_tready, bus_le.s_tready}, 2'b00);
        for (int k = 0; k < n_out; k++) begin
          b.data    = w[k];
          b.keep_be = lane_keep(off, len, k, 1'b1);
          b.keep_le = lane_keep(off, len, k, 1'b0);
          b.last    = (k == n_out - 1);
          b.user    = dst[1:0];
          exp_q.push_back(b);
        end
        err_exp = 0;
`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
        if (n_out > 0 && tl_idx != nw - 1) err_exp = 1;
`endif
      end
      step();
      waits++;
    end while (!rdy && waits < 200);
    check_value("cmd_accept", rdy, 1);
    cmd_valid = 1'b0;

    for (int k = 0; k < n_in; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        step();
      end
      s_tvalid = 1'b1;
      s_tdata  = w[k];
      s_tlast  = (k == tl_idx);
      waits    = 0;
      do begin
        @(negedge aclk);
        rdy = bus_be.s_tready;
        step();
        if (!rdy) waits++;
      end while (!rdy && waits < 200);
      check_value("s_accept", rdy, 1);
      if (!gaps && tr_mode == 0) check_value("throughput_wait", waits, 0);
      if (k < n_out) check_value("latency_valid", {bus_be.m_tvalid, bus_le.m_tvalid}, 2'b11);
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check_value("cmd_ready_after", bus_be.cmd_ready, 1);
    check_value("err_tlast", {bus_be.err_tlast, bus_le.err_tlast}, {2{err_exp[0]}});
  endtask

  task automatic drain_outputs();
    int waits;
    waits = 0;
    while (exp_q.size() != 0 && waits < 300) begin
      step();
      waits++;
    end
    check_value("queue_empty", exp_q.size(), 0);
  endtask

  // Output monitor: consumes expected beats on each handshake and checks stall stability.
  beat_t       mon_e;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic [3:0]  stall_keep;

  always @(negedge aclk) begin
    if (!aresetn) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_value("stall_valid", bus_be.m_tvalid, 1);
        check_value("stall_data", bus_be.m_tdata, stall_data);
        check_value("stall_keep", bus_be.m_tkeep, stall_keep);
      end
      if (bus_be.m_tvalid && m_tready) begin
        check_value("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check_value("m_tdata", bus_be.m_tdata, mon_e.data);
          check_value("m_tkeep_be", bus_be.m_tkeep, mon_e.keep_be);
          check_value("m_tkeep_le", bus_le.m_tkeep, mon_e.keep_le);
          check_value("m_tlast", {bus_be.m_tlast, bus_le.m_tlast}, {2{mon_e.last}});
          check_value("m_tuser", bus_be.m_tuser, mon_e.user);
          check_value("le_valid_data", {bus_le.m_tvalid, bus_le.m_tdata}, {1'b1, mon_e.data});
        end
      end
      stall_prev = bus_be.m_tvalid && !m_tready;
      stall_data = bus_be.m_tdata;
      stall_keep = bus_be.m_tkeep;
    end
  end

  initial begin
    int off;
    int len;
    int nw;
    m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_value("rst_cmd_ready", bus_be.cmd_ready, 1);
    check_value("rst_m_tvalid", {bus_be.m_tvalid, bus_le.m_tvalid}, 2'b00);
    check_value("rst_m_fields", {bus_be.m_tdata, bus_be.m_tkeep, bus_be.m_tlast, bus_be.m_tuser}, '0);
    check_value("rst_err_tlast", bus_be.err_tlast, 0);
    aresetn = 1'b1;
    step();

    // Directed windows with a free-running output.
    tr_mode = 0;
    gaps    = 0;
    din_q   = '{32'h00112233, 32'h44556677};
    run_cmd(1, 6, 2, 2, 1);
    run_cmd(0, 12, 1, 3, 2);
    run_cmd(3, 1, 3, 1, 0);
    run_cmd(0, 0, 0, 0, -1);
    run_cmd(2, 2, 1, 1, 0);
    drain_outputs();

    // Stalls on the output while a 4-word window streams.
    tr_mode = 2;
    tr_pat  = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 1};
    run_cmd(0, 16, 2, 4, 3);
    drain_outputs();

    // Random windows, random gaps and backpressure.
    tr_mode = 1;
    gaps    = 1;
    repeat (40) begin
      off = $urandom_range(0, 3);
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
      nw  = (len == 0) ? 0 : (off + len + 3) / 4;
      run_cmd(off, len, $urandom_range(0, 3), nw, nw - 1);
    end
    drain_outputs();

`ifdef AXIS_BYTE_WINDOW_TLAST_CHECK_EN
    // Early tlast ends the window; missing tlast sends the block through DRAIN.
    tr_mode = 0;
    gaps    = 0;
    run_cmd(0, 8, 1, 1, 0);
    run_cmd(0, 4, 2, 3, 2);
    run_cmd(1, 2, 0, 1, 0);
    drain_outputs();
`endif

    // Reset in the middle of a stalled window.
    tr_mode    = 3;
    step();
    cmd_valid  = 1'b1;
    cmd_offset = 2'd0;
    cmd_len    = LEN_W'(16);
    cmd_dst    = 2'd2;
    @(negedge aclk);
    check_value("mid_cmd_ready", bus_be.cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    s_tvalid  = 1'b1;
    s_tdata   = $urandom();
    step();
    s_tdata   = $urandom();
    step();
    step();
    check_value("mid_stalled_valid", bus_be.m_tvalid, 1);
    aresetn = 1'b0;
    #1;
    check_value("async_rst_valid", {bus_be.m_tvalid, bus_le.m_tvalid}, 2'b00);
    check_value("async_rst_fields", {bus_be.m_tdata, bus_be.m_tkeep, bus_be.m_tlast, bus_be.m_tuser}, '0);
    check_value("async_rst_cmd_ready", bus_be.cmd_ready, 1);
    s_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    @(negedge aclk);
    check_value("post_rst_ready", {bus_be.cmd_ready, bus_be.s_tready}, 2'b10);
    tr_mode = 1;
    step();
    run_cmd(1, 9, 3, 3, 2);
    drain_outputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
